// File: rtl/mapper_pkg.sv
// Shared definitions for the Z80 mapper CPLD: trap FSM states, status port
// offsets inside the mapper I/O window, and status flag bit positions.
package mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_PULSE    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } trap_state_e;

  localparam logic [3:0] MAPPER_BASE  = 4'h2;
  localparam logic [3:0] STATUS_ADDR  = 4'h8;
  localparam logic [3:0] STATUS_DATA  = 4'h9;
  localparam logic [3:0] STATUS_FLAGS = 4'hA;

  localparam int unsigned FLAG_VALID   = 0;
  localparam int unsigned FLAG_DIR     = 1;
  localparam int unsigned FLAG_OVERRUN = 2;
  localparam int unsigned FLAG_TIMEOUT = 3;

  function automatic logic [7:0] pack_flags(input logic valid, input logic dir,
                                            input logic overrun, input logic timeout);
    logic [7:0] f;
    f               = 8'h00;
    f[FLAG_VALID]   = valid;
    f[FLAG_DIR]     = dir;
    f[FLAG_OVERRUN] = overrun;
    f[FLAG_TIMEOUT] = timeout;
    return f;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Two-flop synchroniser for an active-low Z80 strobe, plus a one-clock pulse
// on its synchronised falling edge. Flops reset to the inactive (high) level.
module bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= strobe_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/trap_sequencer.sv
// Z80 I/O trap controller: suppresses trapped I/O cycles, records them, pulses NMI
// and serves status ports 0x28-0x2A. Define TRAP_WATCHDOG_EN to add the ack watchdog.
module trap_sequencer
  import mapper_pkg::*;
#(
  parameter logic [7:0]  TRAP_BASE  = 8'h40,
  parameter logic [7:0]  TRAP_MASK  = 8'hF0,
  parameter int unsigned NMI_CYCLES = 8,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       iorq_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic       trap_en,
  output logic       iorq_sys_n,
  output logic       mreq_sys_n,
  output logic       nmi_n
);

  if (NMI_CYCLES < 1 || NMI_CYCLES > 255 || TIMEOUT_W < 1) begin : g_param_check
    $error("trap_sequencer: NMI_CYCLES must be 1..255 and TIMEOUT_W at least 1");
  end

  trap_state_e state_q;
  logic [7:0]  trap_addr_q;
  logic [7:0]  trap_data_q;
  logic        trap_dir_q;
  logic        valid_q;
  logic        overrun_q;
  logic        timeout_q;
  logic [7:0]  pulse_cnt_q;
  logic        nmi_n_q;

  logic        in_window_s;
  logic        mapper_io_s;
  logic        trap_hit_s;
  logic        iorq_fall_s;
  logic        rd_fall_s;
  logic        hit_fall_s;
  logic        ack_s;

  assign in_window_s = (addr[7:4] == MAPPER_BASE);
  assign mapper_io_s = in_window_s & ~iorq_n;
  // Interrupt acknowledge (m1_n low) and the mapper window itself never trap
  assign trap_hit_s  = trap_en & ((addr & TRAP_MASK) == (TRAP_BASE & TRAP_MASK))
                       & ~in_window_s & ~iorq_n & m1_n;

  assign iorq_sys_n  = iorq_n | trap_hit_s;
  assign mreq_sys_n  = mreq_n;
  assign nmi_n       = nmi_n_q;

  bus_sync u_iorq_sync (
    .clk        (clk),
    .reset      (reset),
    .strobe_n_i (iorq_n),
    .fall_o     (iorq_fall_s)
  );

  bus_sync u_rd_sync (
    .clk        (clk),
    .reset      (reset),
    .strobe_n_i (rd_n),
    .fall_o     (rd_fall_s)
  );

  assign hit_fall_s = iorq_fall_s & trap_hit_s;
  assign ack_s      = rd_fall_s & mapper_io_s & (addr[3:0] == STATUS_FLAGS);

  assign data_oe = mapper_io_s & ~rd_n & (addr[3:2] == 2'b10) & (addr[1:0] != 2'b11);

  // Status read mux; data_oe decides whether it reaches the bus
  always_comb begin
    data_out = 8'h00;
    case (addr[3:0])
      STATUS_ADDR:  data_out = trap_addr_q;
      STATUS_DATA:  data_out = trap_data_q;
      STATUS_FLAGS: data_out = pack_flags(valid_q, trap_dir_q, overrun_q, timeout_q);
      default:      data_out = 8'h00;
    endcase
  end

`ifdef TRAP_WATCHDOG_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] wd_q;
`endif

  // Trap FSM, record, flags and NMI pulse timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      trap_addr_q <= 8'h00;
      trap_data_q <= 8'h00;
      trap_dir_q  <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      pulse_cnt_q <= 8'h00;
      nmi_n_q     <= 1'b1;
`ifdef TRAP_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      if (hit_fall_s && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      // An ack on the same clock as an overrun wins
      if (ack_s && (state_q == ST_IDLE || state_q == ST_WAIT_ACK)) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (hit_fall_s) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          trap_addr_q <= addr;
          trap_dir_q  <= ~wr_n;
          trap_data_q <= wr_n ? 8'h00 : data_in;
          valid_q     <= 1'b1;
          pulse_cnt_q <= 8'(NMI_CYCLES);
          nmi_n_q     <= 1'b0;
          state_q     <= ST_PULSE;
        end
        ST_PULSE: begin
          pulse_cnt_q <= pulse_cnt_q - 8'd1;
          if (pulse_cnt_q == 8'd1) begin
            nmi_n_q <= 1'b1;
            state_q <= ST_WAIT_ACK;
`ifdef TRAP_WATCHDOG_EN
            wd_q    <= '0;
`endif
          end
        end
        ST_WAIT_ACK: begin
          if (ack_s) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            trap_dir_q <= 1'b0;
          end
`ifdef TRAP_WATCHDOG_EN
          else if (wd_q == WD_LAST) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            trap_dir_q <= 1'b0;
            timeout_q  <= 1'b1;
            wd_q       <= '0;
          end else begin
            wd_q <= wd_q + TIMEOUT_W'(1);
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          nmi_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap controller for the Z80 mapper CPLD. When trapping is enabled in the control register, it intercepts Z80 I/O cycles to a configurable port window. It suppresses them toward the system bus, latches the trapped address, direction and write data, and pulses NMI to the Z80. The trap record is then held until software reads it back through the mapper I/O window (0x20–0x2F) and acknowledges it. The block sits beside the register block; it owns `iorq_sys_n`/`mreq_sys_n` generation and the trap status ports 0x28–0x2A.

## Interface
- `TRAP_BASE`, default 8'h40: port address of the trap window.
- `TRAP_MASK`, default 8'hF0: address bits compared against `TRAP_BASE`.
- `NMI_CYCLES`, default 8: `nmi_n` low time in clocks, 1–255.
- `TIMEOUT_W`, default 16: watchdog counter width (used only with the macro).
- `clk`  in  1  free-running CPLD clock.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  8  Z80 A[7:0].
- `data_in`  in  8  Z80 data bus (write data).
- `data_out`  out  8  status read data.
- `data_oe`  out  1  drive `data_out` onto the bus.
- `iorq_n`, `mreq_n`, `rd_n`, `wr_n`, `m1_n`  in  1 each  Z80 strobes, asynchronous to `clk`.
- `trap_en`  in  1  trap-enable bit from the control register.
- `iorq_sys_n`  out  1  gated IORQ to the system bus.
- `mreq_sys_n`  out  1  MREQ to the system bus; pass-through of `mreq_n`.
- `nmi_n`  out  1  NMI to the Z80, active low.

## Operation
- Combinational decodes:
  - mapper_io = (addr[7:4] == 4'h2) & !iorq_n.
  - trap_hit = trap_en & ((addr & TRAP_MASK) == (TRAP_BASE & TRAP_MASK)) & !mapper_io-range & !iorq_n & m1_n. Interrupt acknowledge (m1_n low) never traps.
- `iorq_sys_n` = iorq_n | trap_hit. This path is combinational so system devices never see a trapped strobe.
- `iorq_n` and `rd_n` each pass through a 2-flop synchroniser with falling-edge detect.
- FSM states: IDLE, CAPTURE, PULSE, WAIT_ACK.
  - IDLE → CAPTURE: synchronised IORQ fall while trap_hit.
  - CAPTURE (1 clk): latch trap_addr <= addr, trap_dir <= !wr_n, trap_data <= data_in (writes only; reads latch 8'h00). Set valid. Load the pulse counter with NMI_CYCLES.
  - PULSE: `nmi_n` = 0; counter decrements; → WAIT_ACK when it reaches 1.
  - WAIT_ACK: hold the record; → IDLE on a synchronised RD fall with mapper_io & addr[3:0] == 4'hA. Clear valid and overrun.
- A trap_hit IORQ fall outside IDLE is still suppressed but not recorded; it sets overrun (sticky until ack).
- Status reads: `data_oe` = mapper_io & !rd_n & addr[3:2] == 2'b10 & addr[1:0] != 2'b11.
  - 0x28 returns trap_addr.
  - 0x29 returns trap_data.
  - 0x2A returns flags: bit0 valid, bit1 dir (1 = write), bit2 overrun, bit3 timeout, bits 7:4 = 0.
- Trapped reads are not driven by this block; the bus reads pull-up value 8'hFF.

## Timing
- Reset values: state IDLE, `nmi_n` 1, `data_oe` 0, record and flags 0, counters 0.
- Reset mid-operation aborts immediately: `nmi_n` returns high asynchronously.
- IORQ fall to CAPTURE: 2–3 clks (synchroniser). First `nmi_n` low clock follows CAPTURE.
- `nmi_n` is low for exactly NMI_CYCLES clocks per trap; never re-asserted in WAIT_ACK.
- The ack read is inside the mapper window, so it never traps. Ack and overrun on the same clock: ack wins, overrun is cleared.
- `trap_en` deasserting mid-sequence does not abort; the FSM completes normally.

## Configuration
- `TRAP_WATCHDOG_EN` defined: a TIMEOUT_W-bit counter runs in WAIT_ACK.
  - On terminal count (2^TIMEOUT_W − 1 clks), the FSM goes to IDLE and sets timeout (bit3). valid is cleared; timeout stays until the next ack read or reset.
- Undefined: no counter; WAIT_ACK holds indefinitely and bit3 reads 0.

## Structure
- Shared package `mapper_pkg`:
  - FSM state encoding.
  - Port offsets (STATUS_ADDR 4'h8, STATUS_DATA 4'h9, STATUS_FLAGS 4'hA).
  - Flag bit indices.
  - Mapper window base 4'h2.
- Sub-module `bus_sync`: 2-flop synchroniser plus falling-edge pulse, async reset to 1. Instantiated for `iorq_n` and `rd_n`.

## Test plan
- Write 0x5A to port 0x43, trap_en=1:
  - `iorq_sys_n` stays high throughout.
  - `nmi_n` low for 8 clks.
  - Reads return 0x28 → 0x43, 0x29 → 0x5A, 0x2A → 0x03.
- Read port 0x47 with trap_en=0: `iorq_sys_n` follows `iorq_n`; `nmi_n` stays high; flags 0x00.
- Two trapped writes (0x41, then 0x42) before ack: record holds 0x41; flags = 0x07; after ack read, flags = 0x00.
- Interrupt acknowledge cycle (m1_n=0, iorq_n=0, addr=0x40): not trapped; `iorq_sys_n` low.
- Assert `reset` during PULSE: `nmi_n` goes high immediately; state IDLE; flags 0x00.
- With `TRAP_WATCHDOG_EN`, TIMEOUT_W=4, no ack: 15 clks after WAIT_ACK entry, flags = 0x08; a new trap is accepted.
